// File: rtl/bridge_req_fifo_if.sv
// Request/grant port carrying one bridge request: address, write enable, data, byte enables, ID and aux sideband.
// The master drives the request and payload, and the slave answers with the grant.
interface bridge_req_fifo_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 20,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int AUX_WIDTH  = 6
);
    logic                  data_req;
    logic                  data_gnt;
    logic [ADDR_WIDTH-1:0] data_add;
    logic                  data_wen;
    logic [DATA_WIDTH-1:0] data_wdata;
    logic [BE_WIDTH-1:0]   data_be;
    logic [ID_WIDTH-1:0]   data_id;
    logic [AUX_WIDTH-1:0]  data_aux;

    modport master (
        output data_req, data_add, data_wen, data_wdata, data_be, data_id, data_aux,
        input  data_gnt
    );

    modport slave (
        input  data_req, data_add, data_wen, data_wdata, data_be, data_id, data_aux,
        output data_gnt
    );
endinterface

// File: rtl/bridge_req_fifo.sv
// Elastic in-order request buffer between the arbitration tree output and the slave-side target.
// Defining BRIDGE_REQ_FIFO_BYPASS_EN adds a zero-latency pass-through path and lets a grant flow through while full.
module bridge_req_fifo #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 20,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int AUX_WIDTH  = 6,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    bridge_req_fifo_if.slave             up,
    bridge_req_fifo_if.master            dn,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int PAYLOAD_W = ADDR_WIDTH + 1 + DATA_WIDTH + BE_WIDTH + ID_WIDTH + AUX_WIDTH;

    logic [PAYLOAD_W-1:0] mem [DEPTH];
    logic [PAYLOAD_W-1:0] wr_payload;
    logic [PAYLOAD_W-1:0] rd_payload;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [PTR_W-1:0]     wptr;
    logic [PTR_W-1:0]     rptr;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 store;
    logic                 drain;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign wr_payload = {up.data_add, up.data_wen, up.data_wdata, up.data_be, up.data_id, up.data_aux};
    assign rd_payload = mem[rptr];
    assign push       = up.data_req && up.data_gnt;
    assign pop        = dn.data_req && dn.data_gnt;

`ifdef BRIDGE_REQ_FIFO_BYPASS_EN
    // When empty the request is presented downstream directly; if it is taken there, it is never stored.
    assign up.data_gnt = !full || dn.data_gnt;
    assign dn.data_req = empty ? up.data_req : 1'b1;
    assign out_payload = empty ? wr_payload : rd_payload;
    assign store       = push && !(empty && dn.data_gnt);
    assign drain       = pop && !empty;
`else
    assign up.data_gnt = !full;
    assign dn.data_req = !empty;
    assign out_payload = rd_payload;
    assign store       = push;
    assign drain       = pop;
`endif

    assign {dn.data_add, dn.data_wen, dn.data_wdata, dn.data_be, dn.data_id, dn.data_aux} = out_payload;
    assign count_o = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (store) begin
            mem[wptr] <= wr_payload;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy separately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (store) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (drain) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({store, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
